// File: rtl/std_gf_edge_event_detector.sv
// Multi-channel edge/event detector: per-channel synchronizer, persistence filter,
// registered edge pulses, mode-selected events, sticky pending flag and saturating count.
module std_gf_edge_event_detector #(
  parameter int BIT_WIDTH     = 1,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 1,
  parameter int COUNT_WIDTH   = 8
) (
  input  logic                             i_clk,
  input  logic                             i_reset,
  input  logic [BIT_WIDTH-1:0]             i_signal,
  input  logic [2*BIT_WIDTH-1:0]           i_mode,
  input  logic [BIT_WIDTH-1:0]             i_clear,
  output logic [BIT_WIDTH-1:0]             o_level,
  output logic [BIT_WIDTH-1:0]             o_posedge,
  output logic [BIT_WIDTH-1:0]             o_negedge,
  output logic [BIT_WIDTH-1:0]             o_bothedge,
  output logic [BIT_WIDTH-1:0]             o_event,
  output logic [BIT_WIDTH-1:0]             o_pending,
  output logic [BIT_WIDTH*COUNT_WIDTH-1:0] o_count,
  output logic                             o_irq
);

  // FILTER_CYCLES of 0 and 1 both collapse to "accept on first differing sample".
  localparam int F_EFF   = (FILTER_CYCLES < 1) ? 1 : FILTER_CYCLES;
  localparam int FCW_RAW = $clog2(FILTER_CYCLES + 1);
  localparam int FCW     = (FCW_RAW < 1) ? 1 : FCW_RAW;
  localparam logic [FCW-1:0]         F_LAST  = FCW'(F_EFF - 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + COUNT_WIDTH'(1);
  endfunction

  for (genvar c = 0; c < BIT_WIDTH; c++) begin : g_ch
    logic                   sync_out;
    logic [FCW-1:0]         filt_cnt_p1;
    logic                   level_p1;
    logic                   level_d_p2;
    logic                   pos_p2;
    logic                   neg_p2;
    logic                   both_p2;
    logic                   ev_p2;
    logic                   pend_p3;
    logic [COUNT_WIDTH-1:0] cnt_p3;

    // Stage p0: metastability synchronizer (bypassed when the input is already synchronous)
    if (SYNC_STAGES == 0) begin : g_nosync
      assign sync_out = i_signal[c];
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_p0;
      always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
          sync_p0 <= '0;
        end else begin
          for (int i = SYNC_STAGES - 1; i > 0; i--) sync_p0[i] <= sync_p0[i-1];
          sync_p0[0] <= i_signal[c];
        end
      end
      assign sync_out = sync_p0[SYNC_STAGES-1];
    end

    // Stage p1: persistence filter; a new level must be seen F_EFF consecutive cycles
    always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
        filt_cnt_p1 <= '0;
        level_p1    <= 1'b0;
      end else if (sync_out == level_p1) begin
        filt_cnt_p1 <= '0;
      end else if (filt_cnt_p1 == F_LAST) begin
        filt_cnt_p1 <= '0;
        level_p1    <= sync_out;
      end else begin
        filt_cnt_p1 <= filt_cnt_p1 + FCW'(1);
      end
    end

    // Stage p2: edge pulses and mode-qualified event, all registered on the same edge
    always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
        level_d_p2 <= 1'b0;
        pos_p2     <= 1'b0;
        neg_p2     <= 1'b0;
        both_p2    <= 1'b0;
        ev_p2      <= 1'b0;
      end else begin
        level_d_p2 <= level_p1;
        pos_p2     <= level_p1 & ~level_d_p2;
        neg_p2     <= ~level_p1 & level_d_p2;
        both_p2    <= level_p1 ^ level_d_p2;
        ev_p2      <= (level_p1 & ~level_d_p2 & i_mode[2*c]) |
                      (~level_p1 & level_d_p2 & i_mode[2*c+1]);
      end
    end

    // Stage p3: sticky pending and saturating count; an event coincident with clear wins
    always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
        pend_p3 <= 1'b0;
        cnt_p3  <= '0;
      end else begin
        pend_p3 <= ev_p2 | (pend_p3 & ~i_clear[c]);
        if (i_clear[c])  cnt_p3 <= COUNT_WIDTH'(ev_p2);
        else if (ev_p2)  cnt_p3 <= sat_inc(cnt_p3);
      end
    end

    assign o_level[c]                             = level_p1;
    assign o_posedge[c]                           = pos_p2;
    assign o_negedge[c]                           = neg_p2;
    assign o_bothedge[c]                          = both_p2;
    assign o_event[c]                             = ev_p2;
    assign o_pending[c]                           = pend_p3;
    assign o_count[c*COUNT_WIDTH +: COUNT_WIDTH]  = cnt_p3;
  end

  assign o_irq = |o_pending;

endmodule

// File: tb/tb_std_gf_edge_event_detector.sv
// Randomized bench for std_gf_edge_event_detector: two configurations driven in lockstep
// and compared every cycle against a history-based behavioural model.
module tb_std_gf_edge_event_detector;
  localparam int BW = 4;
  localparam int CW = 2;
  localparam int NI = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [BW-1:0]   sig, clr;
  logic [2*BW-1:0] mode;

  logic [BW-1:0]    a_level [NI];
  logic [BW-1:0]    a_pos   [NI];
  logic [BW-1:0]    a_neg   [NI];
  logic [BW-1:0]    a_both  [NI];
  logic [BW-1:0]    a_ev    [NI];
  logic [BW-1:0]    a_pend  [NI];
  logic [BW*CW-1:0] a_cnt   [NI];
  logic             a_irq   [NI];

  std_gf_edge_event_detector #(.BIT_WIDTH(BW), .SYNC_STAGES(2), .FILTER_CYCLES(4), .COUNT_WIDTH(CW)) dut0 (
    .i_clk(clk), .i_reset(rst_n), .i_signal(sig), .i_mode(mode), .i_clear(clr),
    .o_level(a_level[0]), .o_posedge(a_pos[0]), .o_negedge(a_neg[0]), .o_bothedge(a_both[0]),
    .o_event(a_ev[0]), .o_pending(a_pend[0]), .o_count(a_cnt[0]), .o_irq(a_irq[0]));

  std_gf_edge_event_detector #(.BIT_WIDTH(BW), .SYNC_STAGES(0), .FILTER_CYCLES(1), .COUNT_WIDTH(CW)) dut1 (
    .i_clk(clk), .i_reset(rst_n), .i_signal(sig), .i_mode(mode), .i_clear(clr),
    .o_level(a_level[1]), .o_posedge(a_pos[1]), .o_negedge(a_neg[1]), .o_bothedge(a_both[1]),
    .o_event(a_ev[1]), .o_pending(a_pend[1]), .o_count(a_cnt[1]), .o_irq(a_irq[1]));

  function automatic int s_of(input int i); return (i == 0) ? 2 : 0; endfunction
  function automatic int f_of(input int i); return (i == 0) ? 4 : 1; endfunction

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Model state: input delay line, run length of disagreeing samples, last two levels,
  // last expected event, and events seen since the last clear.
  logic m_d    [NI][BW][4];
  int   m_run  [NI][BW];
  logic m_lv1  [NI][BW];
  logic m_lv2  [NI][BW];
  logic m_ev   [NI][BW];
  logic m_pos  [NI][BW];
  logic m_neg  [NI][BW];
  logic m_pend [NI][BW];
  int   m_nev  [NI][BW];

  task automatic model_reset();
    for (int i = 0; i < NI; i++)
      for (int c = 0; c < BW; c++) begin
        for (int k = 0; k < 4; k++) m_d[i][c][k] = 1'b0;
        m_run[i][c] = 0; m_lv1[i][c] = 1'b0; m_lv2[i][c] = 1'b0;
        m_ev[i][c] = 1'b0; m_pos[i][c] = 1'b0; m_neg[i][c] = 1'b0;
        m_pend[i][c] = 1'b0; m_nev[i][c] = 0;
      end
  endtask

  task automatic model_step(input logic [BW-1:0] s, input logic [2*BW-1:0] md, input logic [BW-1:0] cl);
    for (int i = 0; i < NI; i++)
      for (int c = 0; c < BW; c++) begin
        logic rise, fall, samp;
        rise = m_lv1[i][c] & ~m_lv2[i][c];
        fall = ~m_lv1[i][c] & m_lv2[i][c];
        m_pend[i][c] = m_ev[i][c] | (m_pend[i][c] & ~cl[c]);
        m_nev[i][c]  = cl[c] ? int'(m_ev[i][c]) : m_nev[i][c] + int'(m_ev[i][c]);
        m_pos[i][c]  = rise;
        m_neg[i][c]  = fall;
        m_ev[i][c]   = (rise & md[2*c]) | (fall & md[2*c+1]);
        samp = (s_of(i) == 0) ? s[c] : m_d[i][c][s_of(i)-1];
        for (int k = 3; k > 0; k--) m_d[i][c][k] = m_d[i][c][k-1];
        m_d[i][c][0] = s[c];
        m_lv2[i][c] = m_lv1[i][c];
        if (samp == m_lv1[i][c]) m_run[i][c] = 0;
        else begin
          m_run[i][c]++;
          if (m_run[i][c] >= f_of(i)) begin
            m_lv1[i][c] = samp;
            m_run[i][c] = 0;
          end
        end
      end
  endtask

  task automatic compare_all();
    for (int i = 0; i < NI; i++) begin
      logic [BW-1:0]    el, ep, en, eb, ee, epd;
      logic [BW*CW-1:0] ec;
      for (int c = 0; c < BW; c++) begin
        el[c] = m_lv1[i][c]; ep[c] = m_pos[i][c]; en[c] = m_neg[i][c];
        eb[c] = m_pos[i][c] | m_neg[i][c]; ee[c] = m_ev[i][c]; epd[c] = m_pend[i][c];
        ec[c*CW +: CW] = (m_nev[i][c] > 3) ? 2'd3 : 2'(m_nev[i][c]);
      end
      chk($sformatf("i%0d level", i), 32'(a_level[i]), 32'(el));
      chk($sformatf("i%0d posedge", i), 32'(a_pos[i]), 32'(ep));
      chk($sformatf("i%0d negedge", i), 32'(a_neg[i]), 32'(en));
      chk($sformatf("i%0d bothedge", i), 32'(a_both[i]), 32'(eb));
      chk($sformatf("i%0d event", i), 32'(a_ev[i]), 32'(ee));
      chk($sformatf("i%0d pending", i), 32'(a_pend[i]), 32'(epd));
      chk($sformatf("i%0d count", i), 32'(a_cnt[i]), 32'(ec));
      chk($sformatf("i%0d irq", i), 32'(a_irq[i]), 32'(|epd));
    end
  endtask

  task automatic step(input logic [BW-1:0] s, input logic [2*BW-1:0] md, input logic [BW-1:0] cl);
    sig = s; mode = md; clr = cl;
    @(posedge clk);
    model_step(s, md, cl);
    #1 compare_all();
  endtask

  task automatic chk_zero(input string tag);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("%s i%0d level", tag, i), 32'(a_level[i]), 0);
      chk($sformatf("%s i%0d edges", tag, i), 32'({a_pos[i], a_neg[i], a_both[i], a_ev[i]}), 0);
      chk($sformatf("%s i%0d pend_cnt", tag, i), 32'({a_pend[i], a_cnt[i]}), 0);
      chk($sformatf("%s i%0d irq", tag, i), 32'(a_irq[i]), 0);
    end
  endtask

  // Called 1ns after an active edge: reset lands mid-cycle, is held across two edges.
  task automatic do_reset(input logic [BW-1:0] s_hold);
    #2 rst_n = 1'b0;
    sig = s_hold;
    #1 chk_zero("async_rst");
    model_reset();
    repeat (2) begin
      @(posedge clk);
      #1 chk_zero("held_rst");
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  int hold [BW];

  initial begin
    rst_n = 1'b1; sig = '0; mode = '0; clr = '0;
    #2 rst_n = 1'b0;
    #1 chk_zero("por");
    model_reset();
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Modes {01,10,11,00} on channels 0..3, toggle all channels high then low.
    repeat (10) step(4'hF, 8'h39, 4'h0);
    repeat (10) step(4'h0, 8'h39, 4'h0);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("modes i%0d count", i), 32'(a_cnt[i]), 32'h25);
      chk($sformatf("modes i%0d pending", i), 32'(a_pend[i]), 32'h7);
    end

    // Short glitch is rejected by the 4-cycle filter, a 4-cycle pulse is accepted.
    step(4'h0, 8'hFF, 4'hF);
    repeat (3) step(4'h1, 8'hFF, 4'h0);
    repeat (8) step(4'h0, 8'hFF, 4'h0);
    chk("glitch i0 count", 32'(a_cnt[0]), 0);
    repeat (4) step(4'h1, 8'hFF, 4'h0);
    repeat (10) step(4'h0, 8'hFF, 4'h0);
    chk("pulse4 i0 count", 32'(a_cnt[0][1:0]), 2);

    // Saturation at 3, then clear coincident with a sixth event.
    step(4'h0, 8'h55, 4'hF);
    repeat (5) begin
      repeat (6) step(4'hF, 8'h55, 4'h0);
      repeat (6) step(4'h0, 8'h55, 4'h0);
    end
    for (int i = 0; i < NI; i++) chk($sformatf("sat i%0d count", i), 32'(a_cnt[i]), 32'hFF);
    for (int t = 0; t < 20 && !m_ev[0][0]; t++) step(4'hF, 8'h55, 4'h0);
    if (!m_ev[0][0]) chk("ev6 timeout", 0, 1);
    step(4'hF, 8'h55, 4'h1);
    chk("clr+ev i0 count", 32'(a_cnt[0][1:0]), 1);
    chk("clr+ev i0 pending", 32'(a_pend[0][0]), 1);

    // Input already high while in reset: one rise per channel after release.
    do_reset(4'hF);
    repeat (10) step(4'hF, 8'hFF, 4'h0);
    for (int i = 0; i < NI; i++) chk($sformatf("post_rst i%0d count", i), 32'(a_cnt[i]), 32'h55);

    // Reset in the middle of a filter run discards it.
    repeat (2) step(4'h0, 8'hFF, 4'h0);
    do_reset(4'h0);
    repeat (10) step(4'h0, 8'hFF, 4'h0);

    // Random phase.
    for (int c = 0; c < BW; c++) hold[c] = $urandom_range(1, 7);
    for (int n = 0; n < 500; n++) begin
      logic [BW-1:0]   s, cl;
      logic [2*BW-1:0] md;
      s = sig; md = mode;
      for (int c = 0; c < BW; c++) begin
        hold[c]--;
        if (hold[c] <= 0) begin
          s[c] = ~s[c];
          hold[c] = $urandom_range(1, 7);
        end
      end
      if ($urandom_range(0, 7) == 0) md = 8'($urandom);
      cl = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'h0;
      step(s, md, cl);
      if ($urandom_range(0, 149) == 0) do_reset(4'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
